// File: rtl/hazard_ctrl.sv
`timescale 1ns / 1ps
// hazard_ctrl: pipeline hazard controller for a 5-stage in-order core.
//
// Resolves three kinds of hazard:
//   - load-use: one-cycle stall of PC/IF-ID with a bubble into ID/EX
//   - taken branch/jump resolved in EX: flush IF/ID and bubble ID/EX
//   - multi-cycle multiply: freeze the front of the pipe for MUL_LAT-1 cycles
//     while EX/MEM receives bubbles
//
// Parameters:
//   MUL_LAT          total EX-stage cycles of a multiply (legal 2..15)
//
// Ports:
//   clk              rising-edge clock
//   rst_n            synchronous active-low reset
//   IDEX_MemRead     instruction in EX is a load
//   IDEX_Rt          load destination register in EX
//   IFID_Rs/IFID_Rt  source registers of the instruction in ID
//   EX_BranchTaken   taken branch or jump resolved in EX
//   EX_MulStart      multiply entering its first EX cycle
//   PCWrite, IFID_Write, IDEX_Write         stage register update enables
//   IFID_Flush, IDEX_Bubble, EXMEM_Bubble   load a NOP into that stage register
//   busy             controller is in any state other than RUN
//   stall_cycles     count of cycles with PCWrite=0, saturating
//                    (only when HAZARD_PERFCNT_EN is defined)
//
// Build option:
//   HAZARD_PERFCNT_EN  adds the stall_cycles performance counter and port.

module hazard_ctrl #(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        IDEX_MemRead,
  input  logic [4:0]  IDEX_Rt,
  input  logic [4:0]  IFID_Rs,
  input  logic [4:0]  IFID_Rt,
  input  logic        EX_BranchTaken,
  input  logic        EX_MulStart,
  output logic        PCWrite,
  output logic        IFID_Write,
  output logic        IDEX_Write,
  output logic        IFID_Flush,
  output logic        IDEX_Bubble,
  output logic        EXMEM_Bubble,
  output logic        busy
`ifdef HAZARD_PERFCNT_EN
  ,
  output logic [15:0] stall_cycles
`endif
);

  typedef enum logic [1:0] {
    StRun,
    StLdStall,
    StMulBusy,
    StFlush
  } state_e;

  // The first multiply cycle is spent in RUN, so the freeze covers the rest.
  localparam logic [3:0] MulLoad = 4'(MUL_LAT - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       load_use;

  // Register 0 is hard-wired, so a load to it never creates a dependency.
  assign load_use = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                    ((IDEX_Rt == IFID_Rs) || (IDEX_Rt == IFID_Rt));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    PCWrite      = 1'b1;
    IFID_Write   = 1'b1;
    IDEX_Write   = 1'b1;
    IFID_Flush   = 1'b0;
    IDEX_Bubble  = 1'b0;
    EXMEM_Bubble = 1'b0;

    unique case (state_q)
      StRun: begin
        // Branch wins over everything: the instructions behind it are dead,
        // so stalling for them would be pointless.
        if (EX_BranchTaken) begin
          IFID_Flush  = 1'b1;
          IDEX_Bubble = 1'b1;
          state_d     = StFlush;
        end else if (EX_MulStart) begin
          cnt_d   = MulLoad;
          state_d = StMulBusy;
        end else if (load_use) begin
          PCWrite     = 1'b0;
          IFID_Write  = 1'b0;
          IDEX_Bubble = 1'b1;
          state_d     = StLdStall;
        end
      end

      StLdStall: begin
        // The load has moved on; the held ID instruction now sees the bubble
        // in EX, so no second stall is raised for the same pair.
        if (EX_BranchTaken) begin
          IFID_Flush  = 1'b1;
          IDEX_Bubble = 1'b1;
          state_d     = StFlush;
        end else begin
          state_d = StRun;
        end
      end

      StFlush: begin
        // EX holds the bubble inserted by the flush; anything flagged now is
        // from a squashed instruction.
        state_d = StRun;
      end

      StMulBusy: begin
        PCWrite      = 1'b0;
        IFID_Write   = 1'b0;
        IDEX_Write   = 1'b0;
        EXMEM_Bubble = 1'b1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = StRun;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: begin
        state_d = StRun;
        cnt_d   = 4'd0;
      end
    endcase

    // Outputs stay nominal while reset is held, regardless of state.
    if (!rst_n) begin
      PCWrite      = 1'b1;
      IFID_Write   = 1'b1;
      IDEX_Write   = 1'b1;
      IFID_Flush   = 1'b0;
      IDEX_Bubble  = 1'b0;
      EXMEM_Bubble = 1'b0;
    end
  end

  assign busy = rst_n && (state_q != StRun);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StRun;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERFCNT_EN
  logic [15:0] stall_cycles_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles_q <= 16'd0;
    end else if (!PCWrite && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_q <= stall_cycles_q + 16'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
`timescale 1ns / 1ps
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// stimulus compared against a cycle-level behavioural model.

module tb_hazard_ctrl;

  localparam int MUL_LAT = 4;

  // Packed output view: {PCWrite, IFID_Write, IDEX_Write,
  //                      IFID_Flush, IDEX_Bubble, EXMEM_Bubble, busy}
  localparam logic [6:0] NOM   = 7'b111_000_0;
  localparam logic [6:0] NOMB  = 7'b111_000_1;
  localparam logic [6:0] LDS   = 7'b001_010_0;
  localparam logic [6:0] BR    = 7'b111_110_0;
  localparam logic [6:0] MULF  = 7'b000_001_1;

  logic       clk;
  logic       rst_n;
  logic       IDEX_MemRead;
  logic [4:0] IDEX_Rt;
  logic [4:0] IFID_Rs;
  logic [4:0] IFID_Rt;
  logic       EX_BranchTaken;
  logic       EX_MulStart;
  logic       PCWrite, IFID_Write, IDEX_Write;
  logic       IFID_Flush, IDEX_Bubble, EXMEM_Bubble;
  logic       busy;
`ifdef HAZARD_PERFCNT_EN
  logic [15:0] stall_cycles;
`endif

  logic [6:0] obs;
  assign obs = {PCWrite, IFID_Write, IDEX_Write, IFID_Flush, IDEX_Bubble, EXMEM_Bubble, busy};

  int n_checks = 0;
  int n_fail   = 0;

  hazard_ctrl #(
    .MUL_LAT(MUL_LAT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .IDEX_MemRead  (IDEX_MemRead),
    .IDEX_Rt       (IDEX_Rt),
    .IFID_Rs       (IFID_Rs),
    .IFID_Rt       (IFID_Rt),
    .EX_BranchTaken(EX_BranchTaken),
    .EX_MulStart   (EX_MulStart),
    .PCWrite       (PCWrite),
    .IFID_Write    (IFID_Write),
    .IDEX_Write    (IDEX_Write),
    .IFID_Flush    (IFID_Flush),
    .IDEX_Bubble   (IDEX_Bubble),
    .EXMEM_Bubble  (EXMEM_Bubble),
    .busy          (busy)
`ifdef HAZARD_PERFCNT_EN
    ,
    .stall_cycles  (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic drive(input logic rn, input logic mr, input logic [4:0] rt,
                       input logic [4:0] rs, input logic [4:0] rt2,
                       input logic br, input logic mul);
    rst_n          = rn;
    IDEX_MemRead   = mr;
    IDEX_Rt        = rt;
    IFID_Rs        = rs;
    IFID_Rt        = rt2;
    EX_BranchTaken = br;
    EX_MulStart    = mul;
    #2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 5'd7, 5'd7, 5'd7, (i == 1), (i == 2));
      n_checks++;
      if (obs !== NOM) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got %b, required %b", i, obs, NOM);
      end
      step();
    end
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    n_checks++;
    if (obs !== NOM) begin
      n_fail++;
      $display("FAIL reset_release: got %b, required %b", obs, NOM);
    end
`ifdef HAZARD_PERFCNT_EN
    n_checks++;
    if (stall_cycles !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_stall_cycles: got %0d, required 0", stall_cycles);
    end
`endif
    step();
  endtask

  task automatic test_load_use();
    drive(1'b1, 1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0);
    n_checks++;
    if (obs !== LDS) begin
      n_fail++;
      $display("FAIL load_use_stall: got %b, required %b", obs, LDS);
    end
    step();
    // Same operands still visible: must not stall a second time.
    drive(1'b1, 1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0);
    n_checks++;
    if (obs !== NOMB) begin
      n_fail++;
      $display("FAIL load_use_single_bubble: got %b, required %b", obs, NOMB);
    end
    step();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    n_checks++;
    if (obs !== NOM) begin
      n_fail++;
      $display("FAIL load_use_return: got %b, required %b", obs, NOM);
    end
    step();
    // Match on Rt operand instead of Rs.
    drive(1'b1, 1'b1, 5'd12, 5'd3, 5'd12, 1'b0, 1'b0);
    n_checks++;
    if (obs !== LDS) begin
      n_fail++;
      $display("FAIL load_use_rt_match: got %b, required %b", obs, LDS);
    end
    step();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_load_r0();
    drive(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    n_checks++;
    if (obs !== NOM) begin
      n_fail++;
      $display("FAIL load_r0_no_stall: got %b, required %b", obs, NOM);
    end
    step();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    n_checks++;
    if (obs !== NOM) begin
      n_fail++;
      $display("FAIL load_r0_after: got %b, required %b", obs, NOM);
    end
    step();
  endtask

  task automatic test_branch_priority();
    drive(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    n_checks++;
    if (obs !== BR) begin
      n_fail++;
      $display("FAIL branch_over_load_use: got %b, required %b", obs, BR);
    end
    step();
    // In FLUSH: new branch and hazard are both ignored.
    drive(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    n_checks++;
    if (obs !== NOMB) begin
      n_fail++;
      $display("FAIL flush_state: got %b, required %b", obs, NOMB);
    end
    step();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    n_checks++;
    if (obs !== NOM) begin
      n_fail++;
      $display("FAIL flush_return: got %b, required %b", obs, NOM);
    end
    step();
  endtask

  task automatic test_mul();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    n_checks++;
    if (obs !== NOM) begin
      n_fail++;
      $display("FAIL mul_start: got %b, required %b", obs, NOM);
    end
    step();
    for (int i = 0; i < MUL_LAT - 1; i++) begin
      // Everything is ignored during the freeze.
      drive(1'b1, 1'b1, 5'd6, 5'd6, 5'd6, (i == 0), (i == 1));
      n_checks++;
      if (obs !== MULF) begin
        n_fail++;
        $display("FAIL mul_freeze[%0d]: got %b, required %b", i, obs, MULF);
      end
      step();
    end
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    n_checks++;
    if (obs !== NOM) begin
      n_fail++;
      $display("FAIL mul_return: got %b, required %b", obs, NOM);
    end
    step();
  endtask

  task automatic test_reset_in_mul();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    step();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    n_checks++;
    if (obs !== MULF) begin
      n_fail++;
      $display("FAIL rstmul_first_freeze: got %b, required %b", obs, MULF);
    end
    step();
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    n_checks++;
    if (obs !== NOM) begin
      n_fail++;
      $display("FAIL rstmul_during_reset: got %b, required %b", obs, NOM);
    end
    step();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      n_checks++;
      if (obs !== NOM) begin
        n_fail++;
        $display("FAIL rstmul_after[%0d]: got %b, required %b", i, obs, NOM);
      end
`ifdef HAZARD_PERFCNT_EN
      n_checks++;
      if (stall_cycles !== 16'd0) begin
        n_fail++;
        $display("FAIL rstmul_stall_cycles[%0d]: got %0d, required 0", i, stall_cycles);
      end
`endif
      step();
    end
  endtask

`ifdef HAZARD_PERFCNT_EN
  task automatic test_perfcnt();
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b1, 5'd4, 5'd1, 5'd4, 1'b0, 1'b0);
      step();
      drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      n_checks++;
      if (stall_cycles !== 16'(k + 1)) begin
        n_fail++;
        $display("FAIL perf_after_stall[%0d]: got %0d, required %0d", k, stall_cycles, k + 1);
      end
      step();
    end
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    step();
    for (int i = 0; i < MUL_LAT - 1; i++) begin
      drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    n_checks++;
    if (stall_cycles !== 16'd5) begin
      n_fail++;
      $display("FAIL perf_total: got %0d, required 5", stall_cycles);
    end
    step();
  endtask
`endif

  // Reference model: the pipeline is either frozen for a number of remaining
  // multiply cycles, or recovering for one cycle after a stall or a flush.
  task automatic test_random();
    int   freeze_left;
    bit   after_stall, after_flush;
    bit   luse;
    logic [5:0] outs;
    logic       ebusy;
`ifdef HAZARD_PERFCNT_EN
    int   perf;
`endif
    logic rn, mr, br, mul;
    logic [4:0] rt, rs, rt2;

    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    freeze_left = 0;
    after_stall = 0;
    after_flush = 0;
`ifdef HAZARD_PERFCNT_EN
    perf = 0;
`endif

    for (int i = 0; i < 800; i++) begin
      rn  = ($urandom_range(0, 59) != 0);
      mr  = ($urandom_range(0, 2) == 0);
      rt  = 5'($urandom_range(0, 3));
      rs  = 5'($urandom_range(0, 3));
      rt2 = 5'($urandom_range(0, 3));
      br  = ($urandom_range(0, 7) == 0);
      mul = ($urandom_range(0, 9) == 0);
      if (mul) mr = 1'b0;
      drive(rn, mr, rt, rs, rt2, br, mul);

      luse  = mr && (rt != 0) && (rt == rs || rt == rt2);
      ebusy = rn && (freeze_left > 0 || after_stall || after_flush);
      outs  = NOM[6:1];

      if (!rn) begin
        freeze_left = 0;
        after_stall = 0;
        after_flush = 0;
      end else if (freeze_left > 0) begin
        outs = MULF[6:1];
        freeze_left--;
      end else if (br && !after_flush) begin
        outs = BR[6:1];
        after_flush = 1;
        after_stall = 0;
      end else if (after_stall || after_flush) begin
        after_stall = 0;
        after_flush = 0;
      end else if (mul) begin
        freeze_left = MUL_LAT - 1;
      end else if (luse) begin
        outs = LDS[6:1];
        after_stall = 1;
      end

      n_checks++;
      if (obs !== {outs, ebusy}) begin
        n_fail++;
        $display("FAIL random[%0d]: got %b, required %b", i, obs, {outs, ebusy});
      end
`ifdef HAZARD_PERFCNT_EN
      n_checks++;
      if (stall_cycles !== 16'(perf)) begin
        n_fail++;
        $display("FAIL random_perf[%0d]: got %0d, required %0d", i, stall_cycles, perf);
      end
      if (!rn) perf = 0;
      else if (!outs[5] && perf < 65535) perf++;
`endif
      step();
    end
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < MUL_LAT + 1; i++) step();
  endtask

  initial begin
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_load_r0();
    test_branch_priority();
    test_mul();
    test_reset_in_mul();
`ifdef HAZARD_PERFCNT_EN
    test_perfcnt();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
